// File: rtl/div_pulse_gen.sv
// Multi-channel programmable divider producing registered pulse or square enables.
// Each channel shadows its period/phase/mode and reloads them only at a period boundary.
module div_pulse_gen #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic                      sync,
    input  logic [NUM_CH*CNT_W-1:0]   div_n,
    input  logic [NUM_CH*CNT_W-1:0]   phase,
    input  logic [NUM_CH-1:0]         mode,
    output logic [NUM_CH-1:0]         po_flag,
    output logic [NUM_CH-1:0]         wrap
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] div_reg;
            logic [CNT_W-1:0] ph_reg;
            logic             md_reg;
            logic             po_reg;
            logic             po_next;
            logic             wrap_reg;
            logic             wrap_next;
            logic             at_end;
            logic             restart;
            logic [CNT_W-1:0] ph_eff;

            always_comb begin
                at_end    = (cnt_reg == div_reg);
                // Counter restart and config reload share one condition.
                restart   = !en[gi] || sync || at_end;
                ph_eff    = (ph_reg > div_reg) ? div_reg : ph_reg;
                cnt_next  = restart ? '0 : cnt_reg + CNT_W'(1);
                po_next   = 1'b0;
                if (en[gi]) begin
                    if (md_reg)
                        po_next = (cnt_reg <= (div_reg >> 1));
                    else
                        po_next = (cnt_reg == ph_eff);
                end
                wrap_next = en[gi] && at_end;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    div_reg  <= '0;
                    ph_reg   <= '0;
                    md_reg   <= 1'b0;
                    po_reg   <= 1'b0;
                    wrap_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    po_reg   <= po_next;
                    wrap_reg <= wrap_next;
                    if (restart) begin
                        div_reg <= div_n[gi*CNT_W +: CNT_W];
                        ph_reg  <= phase[gi*CNT_W +: CNT_W];
                        md_reg  <= mode[gi];
                    end
                end
            end

            assign po_flag[gi] = po_reg;
            assign wrap[gi]    = wrap_reg;
        end
    endgenerate

endmodule

// File: doc/div_pulse_gen.md
# div_pulse_gen

Parametrised, multi-channel successor to the fixed divide-by-4 flag generator. Each channel runs an independent counter with a runtime-programmable period, pulse phase and output mode. Output is a registered single-cycle pulse or an approximately 50 % square enable. Sits beside the top-level datapath and supplies slow-rate enables (strobes, sample ticks, LED blink) from the single system clock.

## Interface
Parameters:
- NUM_CH, 2: number of independent channels.
- CNT_W, 8: counter/config width per channel; max period 2^CNT_W cycles.

Ports (channel i occupies bits [i*CNT_W +: CNT_W] of packed buses):
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  restarts the counters of all enabled channels at 0.
- div_n  in  NUM_CH*CNT_W  period minus one; period = div_n+1 cycles.
- phase  in  NUM_CH*CNT_W  count at which pulse mode fires.
- mode  in  NUM_CH  0 = single-cycle pulse, 1 = square wave.
- po_flag  out  NUM_CH  registered channel output.
- wrap  out  NUM_CH  registered one-cycle marker of counter wrap.

## Operation
- Per channel: counter cnt, active config registers div_a, ph_a, md_a (shadowed copies of div_n, phase, mode).
- Config load: div_a/ph_a/md_a <= inputs whenever en=0, on sync (en=1), or on wrap (en=1 and cnt==div_a). Otherwise held. Input changes mid-period never affect the current period.
- Counter update, evaluated in this priority order:
  - rst: cnt <= 0.
  - en=0: cnt <= 0.
  - sync: cnt <= 0.
  - cnt==div_a: cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - No overflow is possible since cnt ≤ div_a.
- Effective phase: ph_e = (ph_a > div_a) ? div_a : ph_a.
- po_flag next value:
  - en=0: 0.
  - md_a=0: (cnt==ph_e).
  - md_a=1: (cnt <= div_a>>1), which gives ceil(period/2) cycles high, starting at cnt=0.
- wrap next value: en & (cnt==div_a).
- div_n=0: period 1. Pulse mode: po_flag continuously 1 while enabled. Square mode: continuously 1.
- sync while en=0: ignored for that channel.
- sync coincident with wrap: same result, cnt <= 0 and config reloads.
- Channels are fully independent except for the shared sync.

## Timing
- Reset: cnt=0, div_a=0, ph_a=0, md_a=0, po_flag=0, wrap=0, all channels.
- Outputs are registered from the current cnt: po_flag/wrap assert one cycle after the matching count.
  - Example: div_n=3, phase=2, mode=0 → cnt 0,1,2,3,0…; po_flag high in the cycle where cnt=3. This reproduces the legacy divide-by-4 flag.
- en 0→1 at edge k: cnt=0 after edge k (held), counting starts. First cnt==ph_e at cycle k+ph_e. po_flag high at edge k+ph_e+1.
- en 1→0: cnt returns to 0 and po_flag/wrap go 0 at the next edge.
- rst mid-period: all state returns to reset values at the next edge; no partial pulse is emitted afterwards.
- Config latency: new div_n/phase/mode take effect from the first count after the next wrap or sync.

## Test plan
- Reset then en=1, div_n=3, phase=2, mode=0 → po_flag pulses every 4 cycles, one cycle wide, coinciding with cnt=3. wrap asserts one cycle after cnt=3 (during cnt=0).
- Ch0 div_n=4, mode=1; ch1 div_n=9, phase=0, mode=0 → ch0 high 3/low 2 repeating; ch1 one pulse per 10 cycles; channels do not interact.
- Change div_n 3→7 at cnt=1 → current period completes in 4 cycles, subsequent periods 8 cycles; no truncated or doubled pulse.
- phase=9 with div_n=5 → pulse fires at cnt=5 (clamped), period 6. Then div_n=0 → po_flag constantly 1 in both modes.
- Both channels offset (ch1 enabled 3 cycles later, same config), assert sync one cycle → both counters 0 on the same edge; outputs aligned thereafter. sync with ch1 en=0 → ch1 stays 0.
- Assert rst for one cycle mid-period (cnt=2) and separately drop en mid-square-high → all outputs 0 next edge; restart matches the en-rise timing above.
